// File: rtl/sr_ff.sv
// sr_ff: bank of WIDTH clocked SR flip-flops with complement outputs and a per-bit S=R=1 flag.
// Optional sticky error summary enabled by defining SR_FF_STICKY_ERR_EN.
module sr_ff #(
    parameter int WIDTH        = 1,
    parameter     RESET_VAL    = 0,
    parameter int INVALID_MODE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qbar,
`ifdef SR_FF_STICKY_ERR_EN
    input  logic             clr_err,
    output logic             err_sticky,
`endif
    output logic [WIDTH-1:0] invalid
);

    // A single-bit RESET_VAL is replicated across the bank; wider values are used as given.
    localparam logic [WIDTH-1:0] RST_VEC = ($bits(RESET_VAL) == 1) ? {WIDTH{RESET_VAL[0]}}
                                                                     : WIDTH'(RESET_VAL);
    localparam int MODE = (INVALID_MODE >= 1 && INVALID_MODE <= 3) ? INVALID_MODE : 0;

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_inv;
    logic [WIDTH-1:0] w_both;
    logic [WIDTH-1:0] w_inv_q;
    logic [WIDTH-1:0] w_q_next;

    always_comb begin
        w_both = S & R;
        case (MODE)
            1:       w_inv_q = '1;
            2:       w_inv_q = '0;
            3:       w_inv_q = ~r_q;
            default: w_inv_q = r_q;
        endcase
        w_q_next = (w_both & w_inv_q) | (~w_both & ~R & (r_q | S));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q   <= RST_VEC;
            r_inv <= '0;
        end else begin
            r_q   <= w_q_next;
            r_inv <= w_both;
        end
    end

    assign Q       = r_q;
    assign Qbar    = ~r_q;
    assign invalid = r_inv;

`ifdef SR_FF_STICKY_ERR_EN
    logic r_err;

    // A fresh illegal input outranks a clear request on the same edge.
    always_ff @(posedge clk) begin
        if (rst)
            r_err <= 1'b0;
        else if (|w_both)
            r_err <= 1'b1;
        else if (clr_err)
            r_err <= 1'b0;
    end

    assign err_sticky = r_err;
`endif

endmodule

// File: tb/tb_sr_ff.sv
// tb_sr_ff: table-driven and scoreboarded checks of sr_ff in every invalid mode and at WIDTH=4.
// Sticky error checks are compiled in when SR_FF_STICKY_ERR_EN is defined.
module tb_sr_ff;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Four 1-bit instances, one per INVALID_MODE, sharing stimulus.
    logic       rst1 = 1'b1;
    logic       s1   = 1'b0;
    logic       r1   = 1'b0;
    logic       clr  = 1'b0;
    logic [3:0] q1, qb1, inv1, es1;

    // Two 4-bit instances sharing stimulus: mode 0 reset to 0, mode 3 reset to replicated 1'b1.
    logic       rst4 = 1'b1;
    logic [3:0] s4   = 4'b0;
    logic [3:0] r4   = 4'b0;
    logic [3:0] qa, qba, inva, qc, qbc, invc;
    logic       esa, esc;

    for (genvar k = 0; k < 4; k++) begin : g_mode
        sr_ff #(.WIDTH(1), .RESET_VAL(1'b0), .INVALID_MODE(k)) u_dut (
            .clk(clk), .rst(rst1), .S(s1), .R(r1),
            .Q(q1[k]), .Qbar(qb1[k]),
`ifdef SR_FF_STICKY_ERR_EN
            .clr_err(clr), .err_sticky(es1[k]),
`endif
            .invalid(inv1[k])
        );
    end

    sr_ff #(.WIDTH(4), .RESET_VAL(4'b0000), .INVALID_MODE(0)) u_w4 (
        .clk(clk), .rst(rst4), .S(s4), .R(r4),
        .Q(qa), .Qbar(qba),
`ifdef SR_FF_STICKY_ERR_EN
        .clr_err(clr), .err_sticky(esa),
`endif
        .invalid(inva)
    );

    sr_ff #(.WIDTH(4), .RESET_VAL(1'b1), .INVALID_MODE(3)) u_rv (
        .clk(clk), .rst(rst4), .S(s4), .R(r4),
        .Q(qc), .Qbar(qbc),
`ifdef SR_FF_STICKY_ERR_EN
        .clr_err(clr), .err_sticky(esc),
`endif
        .invalid(invc)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        else
            pass_cnt++;
    endtask

    // Vector table for the 1-bit bank: q bit k is the expected Q of the mode-k instance.
    typedef struct {
        logic       rst;
        logic       s;
        logic       r;
        logic [3:0] q;
        logic       inv;
    } vec_t;

    typedef struct {
        logic [3:0] q;
        logic [3:0] inv;
    } exp1_t;

    typedef struct {
        logic [3:0] qa;
        logic [3:0] inva;
        logic [3:0] qc;
        logic [3:0] invc;
    } exp4_t;

    exp1_t sb1[$];
    exp4_t sb4[$];
    vec_t  tbl[17];

    logic [3:0] m_qa, m_qc;

    function automatic logic [3:0] mnext(input logic [3:0] q, input logic [3:0] s,
                                         input logic [3:0] r, input int mode);
        logic [3:0] n;
        for (int b = 0; b < 4; b++) begin
            if (s[b] && r[b]) begin
                if (mode == 1)      n[b] = 1'b1;
                else if (mode == 2) n[b] = 1'b0;
                else if (mode == 3) n[b] = ~q[b];
                else                n[b] = q[b];
            end else if (s[b]) n[b] = 1'b1;
            else if (r[b])     n[b] = 1'b0;
            else               n[b] = q[b];
        end
        return n;
    endfunction

    task automatic run_row(input vec_t v);
        exp1_t e, g;
        @(negedge clk);
        rst1 = v.rst; s1 = v.s; r1 = v.r;
        e.q = v.q; e.inv = {4{v.inv}};
        sb1.push_back(e);
        @(posedge clk); #1;
        g = sb1.pop_front();
        chk("q1", q1, g.q);
        chk("qbar1", qb1, ~g.q);
        chk("invalid1", inv1, g.inv);
    endtask

    task automatic push4(input logic rst, input logic [3:0] s, input logic [3:0] r);
        exp4_t e;
        if (rst) begin
            m_qa = 4'b0000; m_qc = 4'b1111;
            e.inva = 4'b0;  e.invc = 4'b0;
        end else begin
            m_qa = mnext(m_qa, s, r, 0);
            m_qc = mnext(m_qc, s, r, 3);
            e.inva = s & r; e.invc = s & r;
        end
        e.qa = m_qa; e.qc = m_qc;
        sb4.push_back(e);
    endtask

    task automatic check4();
        exp4_t g;
        @(posedge clk); #1;
        g = sb4.pop_front();
        chk("q_w4", qa, g.qa);
        chk("qbar_w4", qba, ~g.qa);
        chk("invalid_w4", inva, g.inva);
        chk("q_rv", qc, g.qc);
        chk("qbar_rv", qbc, ~g.qc);
        chk("invalid_rv", invc, g.invc);
    endtask

    task automatic step4(input logic rst, input logic [3:0] s, input logic [3:0] r);
        @(negedge clk);
        rst4 = rst; s4 = s; r4 = r;
        push4(rst, s, r);
        check4();
    endtask

`ifdef SR_FF_STICKY_ERR_EN
    task automatic step_err(input logic s, input logic r, input logic c, input logic exp);
        @(negedge clk);
        s1 = s; r1 = r; clr = c;
        @(posedge clk); #1;
        chk("err_sticky", es1, {4{exp}});
    endtask
`endif

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 4'b0000, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 4'b0000, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 4'b1111, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 4'b1111, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 4'b0000, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 4'b0000, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 4'b1111, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 4'b0011, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 4'b1011, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 4'b1011, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 4'b0000, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 1'b1, 4'b1010, 1'b1};
        tbl[15] = '{1'b1, 1'b1, 1'b1, 4'b0000, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 4'b0000, 1'b0};

        for (int i = 0; i < 17; i++)
            run_row(tbl[i]);

`ifdef SR_FF_STICKY_ERR_EN
        step_err(1'b0, 1'b0, 1'b0, 1'b0);
        step_err(1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++)
            step_err(1'b0, 1'b0, 1'b0, 1'b1);
        step_err(1'b0, 1'b0, 1'b1, 1'b0);
        step_err(1'b1, 1'b1, 1'b1, 1'b1);
        step_err(1'b0, 1'b0, 1'b1, 1'b0);
`endif

        m_qa = 4'b0000; m_qc = 4'b1111;
        step4(1'b1, 4'b0000, 4'b0000);
        step4(1'b1, 4'b0000, 4'b0000);
        step4(1'b0, 4'b0101, 4'b0011);
        step4(1'b0, 4'b1000, 4'b0000);
        step4(1'b0, 4'b0000, 4'b0000);
        step4(1'b1, 4'b1111, 4'b0000);
        step4(1'b0, 4'b0000, 4'b0000);
        step4(1'b0, 4'b1111, 4'b1111);
        step4(1'b0, 4'b0110, 4'b1001);

        // S/R pulses that start and end between edges must leave state untouched.
        @(negedge clk);
        rst4 = 1'b0; s4 = 4'b0000; r4 = 4'b0000;
        push4(1'b0, 4'b0000, 4'b0000);
        #1 s4 = 4'b1111;
        #2 r4 = 4'b1111;
        #1 s4 = 4'b0000; r4 = 4'b0000;
        check4();

        step4(1'b0, 4'b0000, 4'b0000);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
